// File: rtl/game_pkg.sv
// game_pkg
//   Definitions shared by the gameplay blocks:
//   - pixel coordinate width
//   - default HP and player-box geometry
//   - hit-controller state encoding
//   - small geometry helper functions
package game_pkg;

  // Screen and frame geometry.
  localparam int COORD_W           = 12;

  // Player and HP defaults.
  localparam int HP_MAX_DEF        = 5;
  localparam int HP_W_DEF          = 3;
  localparam int PLAYER_W_DEF      = 20;
  localparam int PLAYER_H_DEF      = 20;
  localparam int INVULN_FRAMES_DEF = 60;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_INVULN = 2'd2,
    ST_DEAD   = 2'd3
  } hit_state_e;

  // Inclusive range test on widened coordinates, so the upper bound never wraps.
  function automatic logic in_span(input logic [COORD_W:0] p,
                                   input logic [COORD_W:0] lo,
                                   input logic [COORD_W:0] hi);
    return (p >= lo) && (p <= hi);
  endfunction

  // The raster origin marks the single start-of-frame cycle.
  function automatic logic is_frame_start(input logic [COORD_W-1:0] h,
                                          input logic [COORD_W-1:0] v);
    return (h == {COORD_W{1'b0}}) && (v == {COORD_W{1'b0}});
  endfunction

endpackage

// File: rtl/box_overlap_cmp.sv
// box_overlap_cmp
//   Registered point-in-box comparator with one cycle of latency.
//   The coordinate (0,0) is the "no pixel" marker and never overlaps.
//
// Ports
//   clk_i       clock
//   rst_ni      synchronous, active-low reset (clears the result)
//   pt_x_i      point x coordinate (0 = none)
//   pt_y_i      point y coordinate (0 = none)
//   box_x_i     box left edge
//   box_y_i     box top edge
//   overlap_o   registered point-in-box result
module box_overlap_cmp
  import game_pkg::*;
#(
  parameter int BOX_W = PLAYER_W_DEF,
  parameter int BOX_H = PLAYER_H_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [COORD_W-1:0] pt_x_i,
  input  logic [COORD_W-1:0] pt_y_i,
  input  logic [COORD_W-1:0] box_x_i,
  input  logic [COORD_W-1:0] box_y_i,
  output logic               overlap_o
);

  localparam logic [COORD_W:0] SPAN_X = (COORD_W+1)'(BOX_W - 1);
  localparam logic [COORD_W:0] SPAN_Y = (COORD_W+1)'(BOX_H - 1);

  logic             valid_s;
  logic [COORD_W:0] px_s;
  logic [COORD_W:0] py_s;
  logic [COORD_W:0] bx_lo_s;
  logic [COORD_W:0] by_lo_s;
  logic [COORD_W:0] bx_hi_s;
  logic [COORD_W:0] by_hi_s;
  logic             ovl_d;
  logic             ovl_q;

  // Widen to one extra bit so that box_x + W - 1 cannot wrap near the screen edge.
  always_comb begin
    valid_s = (pt_x_i != {COORD_W{1'b0}}) && (pt_y_i != {COORD_W{1'b0}});
    px_s    = {1'b0, pt_x_i};
    py_s    = {1'b0, pt_y_i};
    bx_lo_s = {1'b0, box_x_i};
    by_lo_s = {1'b0, box_y_i};
    bx_hi_s = bx_lo_s + SPAN_X;
    by_hi_s = by_lo_s + SPAN_Y;
    ovl_d   = valid_s && in_span(px_s, bx_lo_s, bx_hi_s) && in_span(py_s, by_lo_s, by_hi_s);
  end

  // Result register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ovl_q <= 1'b0;
    end else begin
      ovl_q <= ovl_d;
    end
  end

  assign overlap_o = ovl_q;

endmodule

// File: rtl/player_hit_controller.sv
// player_hit_controller
//   Checks obstacle pixels against the player box and tracks the player's HP.
//   After each hit it runs a number of invulnerability frames.
//   It raises game_over when HP reaches zero.
//   All outputs are registered.
//   The latency from an obstacle pixel to hit is 2 pclk.
//
// Ports
//   pclk          pixel clock
//   rst_n         synchronous, active-low reset
//   hcount_in     raster x; (0,0) is the frame tick
//   vcount_in     raster y
//   game_on       gameplay active
//   menu_on       menu shown; aborts gameplay
//   obstacle_x    obstacle pixel x (0 = none)
//   obstacle_y    obstacle pixel y (0 = none)
//   player_x      player box left edge
//   player_y      player box top edge
//   hp            remaining HP
//   hit           one-cycle damage pulse
//   invulnerable  invulnerability frames running
//   game_over     HP reached zero (held until next game start)
module player_hit_controller
  import game_pkg::*;
#(
  parameter int HP_MAX        = HP_MAX_DEF,
  parameter int HP_W          = HP_W_DEF,
  parameter int PLAYER_W      = PLAYER_W_DEF,
  parameter int PLAYER_H      = PLAYER_H_DEF,
  parameter int INVULN_FRAMES = INVULN_FRAMES_DEF
) (
  input  logic               pclk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] hcount_in,
  input  logic [COORD_W-1:0] vcount_in,
  input  logic               game_on,
  input  logic               menu_on,
  input  logic [COORD_W-1:0] obstacle_x,
  input  logic [COORD_W-1:0] obstacle_y,
  input  logic [COORD_W-1:0] player_x,
  input  logic [COORD_W-1:0] player_y,
  output logic [HP_W-1:0]    hp,
  output logic               hit,
  output logic               invulnerable,
  output logic               game_over
);

  localparam int              CNT_W    = $clog2(INVULN_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INVULN_FRAMES - 1);
  localparam logic [HP_W-1:0]  HP_LOAD  = HP_W'(HP_MAX);

  hit_state_e       state_q, state_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  logic             hit_q, hit_d;
  logic             inv_q, inv_d;
  logic             over_q, over_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic ovl_s;
  logic fstart_s;
  logic abort_s;
  logic last_hp_s;

  box_overlap_cmp #(
    .BOX_W (PLAYER_W),
    .BOX_H (PLAYER_H)
  ) u_box_overlap_cmp (
    .clk_i     (pclk),
    .rst_ni    (rst_n),
    .pt_x_i    (obstacle_x),
    .pt_y_i    (obstacle_y),
    .box_x_i   (player_x),
    .box_y_i   (player_y),
    .overlap_o (ovl_s)
  );

  // Per-cycle condition decode.
  always_comb begin
    fstart_s  = is_frame_start(hcount_in, vcount_in);
    abort_s   = menu_on || !game_on;
    // A hit at HP <= 1 is fatal, so HP can never underflow.
    last_hp_s = (hp_q <= HP_W'(1));
  end

  // Register every piece of state; reset clears everything, including a pending hit.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hp_q    <= {HP_W{1'b0}};
      hit_q   <= 1'b0;
      inv_q   <= 1'b0;
      over_q  <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      hit_q   <= hit_d;
      inv_q   <= inv_d;
      over_q  <= over_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; an abort outranks a same-cycle overlap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!abort_s) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (abort_s) begin
          state_d = ST_IDLE;
        end else if (ovl_s) begin
          state_d = last_hp_s ? ST_DEAD : ST_INVULN;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_INVULN: begin
        if (abort_s) begin
          state_d = ST_IDLE;
        end else if (fstart_s && (cnt_q == CNT_LAST)) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_INVULN;
        end
      end
      ST_DEAD: begin
        if (abort_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DEAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs and the frame counter; hp and game_over survive an abort.
  always_comb begin
    hp_d   = hp_q;
    hit_d  = 1'b0;
    inv_d  = inv_q;
    over_d = over_q;
    cnt_d  = cnt_q;
    case (state_q)
      ST_IDLE: begin
        inv_d = 1'b0;
        if (!abort_s) begin
          hp_d   = HP_LOAD;
          over_d = 1'b0;
          cnt_d  = {CNT_W{1'b0}};
        end else begin
          hp_d   = hp_q;
          over_d = over_q;
        end
      end
      ST_ARMED: begin
        if (abort_s) begin
          inv_d = 1'b0;
        end else if (ovl_s) begin
          hit_d = 1'b1;
          if (last_hp_s) begin
            hp_d   = {HP_W{1'b0}};
            over_d = 1'b1;
          end else begin
            hp_d  = hp_q - HP_W'(1);
            cnt_d = {CNT_W{1'b0}};
            inv_d = 1'b1;
          end
        end else begin
          inv_d = 1'b0;
        end
      end
      ST_INVULN: begin
        if (abort_s) begin
          inv_d = 1'b0;
        end else if (fstart_s) begin
          if (cnt_q == CNT_LAST) begin
            inv_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_DEAD: begin
        inv_d = 1'b0;
        if (abort_s) begin
          over_d = over_q;
        end else begin
          hp_d   = {HP_W{1'b0}};
          over_d = 1'b1;
        end
      end
      default: begin
        hp_d   = {HP_W{1'b0}};
        inv_d  = 1'b0;
        over_d = 1'b0;
        cnt_d  = {CNT_W{1'b0}};
      end
    endcase
  end

  assign hp           = hp_q;
  assign hit          = hit_q;
  assign invulnerable = inv_q;
  assign game_over    = over_q;

endmodule
